// File: rtl/dmux_4way_16.sv
// 1-to-4 word demultiplexer with a one-hot select decode and a registered copy of sel.
// Define DMUX4WAY16_OUT_REG_EN to register a/b/c/d and sel_onehot (1-cycle latency).
module dmux_4way_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [3:0]       sel_onehot,
    output logic [1:0]       last_sel
);

    localparam int NUM_OUT = 4;

    logic [NUM_OUT-1:0]            onehot_c;
    logic [NUM_OUT-1:0][WIDTH-1:0] route_c;

    // Unmatched sel values (X/Z) fall to the default, so no output sees X.
    always_comb begin
        onehot_c = '0;
        case (sel)
            2'b00:   onehot_c = 4'b0001;
            2'b01:   onehot_c = 4'b0010;
            2'b10:   onehot_c = 4'b0100;
            2'b11:   onehot_c = 4'b1000;
            default: onehot_c = '0;
        endcase
    end

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_route
        assign route_c[i] = onehot_c[i] ? in : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) last_sel <= '0;
        else        last_sel <= sel;
    end

`ifdef DMUX4WAY16_OUT_REG_EN
    logic [NUM_OUT-1:0][WIDTH-1:0] route_q;
    logic [NUM_OUT-1:0]            onehot_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            route_q  <= '0;
            onehot_q <= '0;
        end else begin
            route_q  <= route_c;
            onehot_q <= onehot_c;
        end
    end

    assign a          = route_q[0];
    assign b          = route_q[1];
    assign c          = route_q[2];
    assign d          = route_q[3];
    assign sel_onehot = onehot_q;
`else
    // Reset deliberately leaves the routing path alone.
    assign a          = route_c[0];
    assign b          = route_c[1];
    assign c          = route_c[2];
    assign d          = route_c[3];
    assign sel_onehot = onehot_c;
`endif

endmodule

// File: tb/tb_dmux_4way_16.sv
// Directed table-driven bench for dmux_4way_16; follows DMUX4WAY16_OUT_REG_EN when defined.
module tb_dmux_4way_16;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] in;
    logic [1:0]   sel;
    logic [W-1:0] a, b, c, d;
    logic [3:0]   sel_onehot;
    logic [1:0]   last_sel;

    int n_cmp;
    int n_bad;

    dmux_4way_16 #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .sel(sel),
        .a(a), .b(b), .c(c), .d(d),
        .sel_onehot(sel_onehot), .last_sel(last_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] in;
        logic [1:0]   sel;
        logic [W-1:0] ea, eb, ec, ed;
        logic [3:0]   eoh;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input logic [W-1:0] ea, eb, ec, ed,
                            input logic [3:0] eoh);
        chk({name, ".abcd"}, {a, b, c, d}, {ea, eb, ec, ed});
        chk({name, ".onehot"}, {60'd0, sel_onehot}, {60'd0, eoh});
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        vecs[0] = '{16'h0000, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0001};
        vecs[1] = '{16'b0000010000100110, 2'b10, 16'h0000, 16'h0000, 16'b0000010000100110, 16'h0000, 4'b0100};
        vecs[2] = '{16'b0010011111100000, 2'b00, 16'b0010011111100000, 16'h0000, 16'h0000, 16'h0000, 4'b0001};
        vecs[3] = '{16'b0100111010101010, 2'b01, 16'h0000, 16'b0100111010101010, 16'h0000, 16'h0000, 4'b0010};
        vecs[4] = '{16'hFFFF, 2'b11, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 4'b1000};
        vecs[5] = '{16'h0000, 2'b11, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b1000};
        vecs[6] = '{16'hA5A5, 2'b01, 16'h0000, 16'hA5A5, 16'h0000, 16'h0000, 4'b0010};
        vecs[7] = '{16'h8001, 2'b10, 16'h0000, 16'h0000, 16'h8001, 16'h0000, 4'b0100};

        // Reset state
        rst_n = 1'b0;
        in    = '0;
        sel   = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.last_sel", {62'd0, last_sel}, 64'd0);
`ifdef DMUX4WAY16_OUT_REG_EN
        chk_outs("reset", 16'h0, 16'h0, 16'h0, 16'h0, 4'b0000);
`else
        chk_outs("reset", 16'h0, 16'h0, 16'h0, 16'h0, 4'b0001);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in  = vecs[i].in;
            sel = vecs[i].sel;
`ifdef DMUX4WAY16_OUT_REG_EN
            @(posedge clk);
`endif
            #1;
            chk_outs($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].ec, vecs[i].ed, vecs[i].eoh);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.last_sel", i), {62'd0, last_sel}, {62'd0, vecs[i].sel});
        end

        // Synchronous reset clears last_sel; combinational path keeps routing meanwhile
        @(negedge clk);
        rst_n = 1'b0;
        in    = 16'h1234;
        sel   = 2'b11;
`ifndef DMUX4WAY16_OUT_REG_EN
        #1;
        chk_outs("in_reset", 16'h0, 16'h0, 16'h0, 16'h1234, 4'b1000);
`endif
        @(posedge clk);
        #1;
        chk("rst.last_sel", {62'd0, last_sel}, 64'd0);
`ifdef DMUX4WAY16_OUT_REG_EN
        chk_outs("rst_hold", 16'h0, 16'h0, 16'h0, 16'h0, 4'b0000);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        sel   = 2'b10;
        in    = 16'h00F0;
        @(posedge clk);
        #1;
        chk("post_rst.last_sel", {62'd0, last_sel}, 64'd2);

`ifdef DMUX4WAY16_OUT_REG_EN
        // Registered outputs: zero before the edge, data after it
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        in    = 16'b1011101000110011;
        sel   = 2'b11;
        #1;
        chk("reg.pre_edge.d", {48'd0, d}, 64'd0);
        @(posedge clk);
        #1;
        chk_outs("reg.post_edge", 16'h0, 16'h0, 16'h0, 16'b1011101000110011, 4'b1000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
